// File: rtl/mem_arbiter.sv
// Two-master arbiter for a shared synchronous-read memory with a 1-cycle read latency.
// M0 is the instruction-fetch port and is read-only. M1 is the load/store port.
// Each granted request runs one memory cycle and then returns a one-cycle ack.
// A request outside the memory window is never forwarded to the memory; it completes with an error flag.
//
// state | meaning
// IDLE  | wait for an eligible request; grant it and latch its address/data
// ISSUE | drive one memory cycle (suppressed when the address is out of window)
// RESP  | capture read data into the owner's register and arm its ack/err pulse
module mem_arbiter #(
  parameter logic [15:0] BASE_ADDR = 16'h2000,
  parameter int          MEM_SIZE  = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_req,
  input  logic [15:0] i_m0_addr,
  output logic        o_m0_ack,
  output logic [15:0] o_m0_r_data,
  output logic        o_m0_err,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [15:0] i_m1_addr,
  input  logic [15:0] i_m1_w_data,
  output logic        o_m1_ack,
  output logic [15:0] o_m1_r_data,
  output logic        o_m1_err,
  output logic        o_mem_ce,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_w_data,
  input  logic [15:0] i_mem_r_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  // 17-bit window bounds, so that the top of the window cannot wrap past 16'hFFFF.
  localparam logic [16:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [16:0] WIN_HI = WIN_LO + 17'(MEM_SIZE);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;      // 1: M1 owns the current access
  logic        last_m1_q, last_m1_d;  // round-robin pointer, 1: M1 was granted last
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        in_range_q, in_range_d;
  logic        m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
  logic        m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
  logic [15:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic        elig0, elig1, pick_m1;
  logic [15:0] sel_addr;
  logic [16:0] sel_addr17;

  // Grant selection: a master that is in its ack cycle is masked.
  // Because of this mask, a req that is still held during the ack cycle does not start a second access.
  always_comb begin
    elig0      = i_m0_req & ~m0_ack_q;
    elig1      = i_m1_req & ~m1_ack_q;
    pick_m1    = elig1 & (~elig0 | ~last_m1_q);
    sel_addr   = pick_m1 ? i_m1_addr : i_m0_addr;
    sel_addr17 = {1'b0, sel_addr};
  end

  // Next-state and datapath update for the IDLE -> ISSUE -> RESP access cycle.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_m1_d  = last_m1_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    in_range_d = in_range_q;
    m0_ack_d   = 1'b0;
    m0_err_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m1_err_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          owner_d    = pick_m1;
          last_m1_d  = pick_m1;
          addr_d     = sel_addr;
          we_d       = pick_m1 & i_m1_we;
          wdata_d    = pick_m1 ? i_m1_w_data : wdata_q;
          in_range_d = (sel_addr17 >= WIN_LO) && (sel_addr17 < WIN_HI);
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (owner_q) begin
          m1_ack_d = 1'b1;
          m1_err_d = ~in_range_q;
          if (!in_range_q)  m1_rdata_d = 16'h0000;
          else if (!we_q)   m1_rdata_d = i_mem_r_data;
        end else begin
          m0_ack_d = 1'b1;
          m0_err_d = ~in_range_q;
          if (!in_range_q)  m0_rdata_d = 16'h0000;
          else              m0_rdata_d = i_mem_r_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. An asynchronous reset also kills any memory cycle that is in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_m1_q  <= 1'b1;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      we_q       <= 1'b0;
      in_range_q <= 1'b0;
      m0_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= 16'h0000;
      m1_rdata_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_m1_q  <= last_m1_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      in_range_q <= in_range_d;
      m0_ack_q   <= m0_ack_d;
      m0_err_q   <= m0_err_d;
      m1_ack_q   <= m1_ack_d;
      m1_err_q   <= m1_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Memory strobes are decoded from the registered state, so they drop as soon as reset is asserted.
  always_comb begin
    o_mem_ce     = (state_q == ISSUE) & in_range_q;
    o_mem_we     = o_mem_ce & we_q;
    o_mem_addr   = addr_q;
    o_mem_w_data = wdata_q;
    o_m0_ack     = m0_ack_q;
    o_m0_err     = m0_err_q;
    o_m0_r_data  = m0_rdata_q;
    o_m1_ack     = m1_ack_q;
    o_m1_err     = m1_err_q;
    o_m1_r_data  = m1_rdata_q;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one synchronous-read, 1-cycle-latency program/data memory between the CPU instruction-fetch port (M0, read-only) and the CPU load/store port (M1, read/write). It latches each granted request, drives a single memory access cycle, captures the read data and returns it with a one-cycle acknowledge pulse. Requests outside the memory window complete with an error flag and are never forwarded to the memory. Sits between the core's bus ports and the ROM/RAM instance.

## Interface

- BASE_ADDR, 16'h2000, first word address of the memory window
- MEM_SIZE, 1024, window size in words; valid addresses are BASE_ADDR to BASE_ADDR+MEM_SIZE-1
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_m0_req  in  1  fetch request, held until o_m0_ack
- i_m0_addr  in  16  fetch word address, stable while i_m0_req=1
- o_m0_ack  out  1  one-cycle completion pulse
- o_m0_r_data  out  16  fetch data, valid when o_m0_ack=1, held until next M0 ack
- o_m0_err  out  1  out-of-window flag, qualified by o_m0_ack
- i_m1_req  in  1  data request, held until o_m1_ack
- i_m1_we  in  1  1=write, 0=read
- i_m1_addr  in  16  data word address
- i_m1_w_data  in  16  write data
- o_m1_ack  out  1  one-cycle completion pulse
- o_m1_r_data  out  16  read data, valid when o_m1_ack=1 and i_m1_we was 0; held otherwise
- o_m1_err  out  1  out-of-window flag, qualified by o_m1_ack
- o_mem_ce  out  1  memory access enable
- o_mem_we  out  1  memory write enable (only with o_mem_ce)
- o_mem_addr  out  16  memory word address (absolute, memory subtracts base)
- o_mem_w_data  out  16  memory write data
- i_mem_r_data  in  16  memory read data, valid the cycle after o_mem_ce

## Operation

- States: IDLE, ISSUE, RESP.
- IDLE: eligible requester = i_mX_req=1 and o_mX_ack=0 in that cycle (masks the requester still holding req during its ack cycle). If none eligible, stay. If one, grant it. If both, grant the one not granted last (round-robin pointer); pointer resets to "M1 last" so M0 wins the first tie.
- On grant (IDLE edge): latch owner, addr, we (M0 forces 0), w_data; compute in_range = addr>=BASE_ADDR and addr<BASE_ADDR+MEM_SIZE using 17-bit compare (no wrap); update pointer; go to ISSUE.
- ISSUE: o_mem_ce=in_range, o_mem_we=in_range&we, o_mem_addr/o_mem_w_data = latched values. Next edge -> RESP.
- RESP: if in_range and read, capture i_mem_r_data into owner's r_data register; if out of range, load owner's r_data with 16'h0000; writes leave r_data unchanged. Set owner's ack=1 and err=~in_range for the next cycle. Go to IDLE.
- Ack/err are registered single-cycle pulses; only the owner's ack asserts; both acks never high together.
- o_mem_addr/o_mem_w_data hold latched values outside ISSUE; o_mem_ce/o_mem_we are 0 outside ISSUE.
- Requests changing address while req=1 before grant are legal; values are sampled only at the grant edge.

## Timing

- Reset (async, immediate): state IDLE, all acks/errs 0, o_mem_ce/we 0, o_mem_addr/o_mem_w_data 0, both r_data 0, pointer "M1 last". Reset during ISSUE kills the memory access in the same cycle; no ack is produced afterwards.
- Req high at edge E0 (state IDLE) -> ISSUE during cycle after E0 -> RESP next cycle -> ack high in the third cycle after E0 (latency 3 cycles, edge-to-ack).
- Throughput: one access per 3 cycles; a request eligible in the ack cycle of the other master is granted on that edge (back-to-back).
- Master holding req through its ack cycle and dropping it the next cycle causes no duplicate access; master keeping req high after ack starts a new access.
- Continuous requests from both: grants strictly alternate M0, M1, M0, ...

## Test plan

- Reset, single M0 read of 16'h2005 (mem word 5 = 16'hBEEF) -> o_mem_ce=1 addr 16'h2005 one cycle, o_m0_ack 3 cycles after request edge, o_m0_r_data=16'hBEEF, err=0.
- M1 write 16'h1234 to 16'h2010, then M1 read 16'h2010 -> one cycle o_mem_we=1 with data 16'h1234; read ack returns 16'h1234; o_m1_r_data unchanged after write ack.
- Both request from reset, held continuously for 6 accesses -> grant order M0,M1,M0,M1,M0,M1; never both acks high; one access per 3 cycles.
- M0 read 16'h1FFF and M1 read 16'h2400 (BASE+SIZE) and 16'hFFFF -> o_mem_ce never asserted, ack with err=1, r_data=0; 16'h23FF completes with err=0.
- Master holds req through ack then drops -> exactly one memory access per request; keep req high -> second access granted 1 cycle after ack.
- Assert i_rst_n=0 during ISSUE of an M1 write -> o_mem_ce/o_mem_we drop immediately, no ack, next request after release completes normally with M0 winning a tie.
